// File: rtl/core_imem_bus_responder_if.sv
// IFU fetch bus between the fetch unit (master) and the instruction memory (slave).
// bus_rsp_err exists only when IMEM_BUS_ERR_EN is defined.
interface core_imem_bus_responder_if;
  logic        bus_req_valid;
  logic [31:0] bus_req_addr;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
`ifdef IMEM_BUS_ERR_EN
  logic        bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_addr,
    input  bus_rsp_valid, bus_rsp_data, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_addr,
    output bus_rsp_valid, bus_rsp_data, bus_rsp_err
  );
`else
  modport master (
    output bus_req_valid, bus_req_addr,
    input  bus_rsp_valid, bus_rsp_data
  );

  modport slave (
    input  bus_req_valid, bus_req_addr,
    output bus_rsp_valid, bus_rsp_data
  );
`endif
endinterface

// File: rtl/core_imem_bus_responder.sv
// Fixed-latency, in-order instruction memory responder with a side load port.
// Optional macro IMEM_BUS_ERR_EN adds bus_rsp_err for misaligned or out-of-range requests.
module core_imem_bus_responder #(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned LATENCY = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  core_imem_bus_responder_if.slave       bus,
  input  logic                           load_valid,
  input  logic [31:0]                    load_addr,
  input  logic [31:0]                    load_data,
  output logic                           busy,
  output logic [31:0]                    rsp_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] load_idx;
  logic              req_oor;
  logic              load_oor;
  logic              unused_addr_lsb;

  assign req_idx  = bus.bus_req_addr[ADDR_W+1:2];
  assign load_idx = load_addr[ADDR_W+1:2];
  assign req_oor  = (bus.bus_req_addr >> (ADDR_W + 2)) != '0;
  assign load_oor = (load_addr >> (ADDR_W + 2)) != '0;
  assign unused_addr_lsb = ^{bus.bus_req_addr[1:0], load_addr[1:0]};

  // Program memory is never reset; the nonblocking write gives read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (load_valid && !load_oor) begin
      mem[load_idx] <= load_data;
    end
  end

  logic [LATENCY-1:0] stg_vld;
  logic [31:0]        stg_dat [LATENCY];
`ifdef IMEM_BUS_ERR_EN
  logic [LATENCY-1:0] stg_err;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_vld[0] <= 1'b0;
      stg_dat[0] <= '0;
`ifdef IMEM_BUS_ERR_EN
      stg_err[0] <= 1'b0;
`endif
    end else begin
      stg_vld[0] <= bus.bus_req_valid;
      if (bus.bus_req_valid) begin
        stg_dat[0] <= req_oor ? '0 : mem[req_idx];
      end
`ifdef IMEM_BUS_ERR_EN
      stg_err[0] <= bus.bus_req_valid & (req_oor | (bus.bus_req_addr[1:0] != 2'b00));
`endif
    end
  end

  for (genvar s = 1; s < LATENCY; s++) begin : g_stage
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stg_vld[s] <= 1'b0;
        stg_dat[s] <= '0;
`ifdef IMEM_BUS_ERR_EN
        stg_err[s] <= 1'b0;
`endif
      end else begin
        stg_vld[s] <= stg_vld[s-1];
        stg_dat[s] <= stg_dat[s-1];
`ifdef IMEM_BUS_ERR_EN
        stg_err[s] <= stg_err[s-1];
`endif
      end
    end
  end

  assign bus.bus_rsp_valid = stg_vld[LATENCY-1];
  assign bus.bus_rsp_data  = stg_dat[LATENCY-1];
`ifdef IMEM_BUS_ERR_EN
  assign bus.bus_rsp_err   = stg_err[LATENCY-1];
`endif
  assign busy = |stg_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_count <= '0;
    end else if (stg_vld[LATENCY-1]) begin
      rsp_count <= rsp_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_imem_bus_responder.sv
// Bench for core_imem_bus_responder: LATENCY=3 and LATENCY=1 instances share one stimulus
// stream and are checked every cycle against a request-log model of the fetch bus.
module tb_core_imem_bus_responder;
  localparam int unsigned ADDR_W    = 17;
  localparam logic [31:0] MEM_BYTES = 32'd4 << ADDR_W;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        rv   = 1'b0;
  logic [31:0] ra   = '0;
  logic        lv   = 1'b0;
  logic [31:0] la   = '0;
  logic [31:0] ld   = '0;
  logic        busy3, busy1;
  logic [31:0] cnt3, cnt1;
  logic        err3, err1;

  core_imem_bus_responder_if bus3();
  core_imem_bus_responder_if bus1();

  assign bus3.bus_req_valid = rv;
  assign bus3.bus_req_addr  = ra;
  assign bus1.bus_req_valid = rv;
  assign bus1.bus_req_addr  = ra;
`ifdef IMEM_BUS_ERR_EN
  assign err3 = bus3.bus_rsp_err;
  assign err1 = bus1.bus_rsp_err;
`else
  assign err3 = 1'b0;
  assign err1 = 1'b0;
`endif

  core_imem_bus_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .bus(bus3),
    .load_valid(lv), .load_addr(la), .load_data(ld),
    .busy(busy3), .rsp_count(cnt3)
  );

  core_imem_bus_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1),
    .load_valid(lv), .load_addr(la), .load_data(ld),
    .busy(busy1), .rsp_count(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;

  rsp_t        req_log [int];          // edge number -> expected response of the request sampled there
  logic [31:0] mm [int unsigned];      // word index -> contents
  int          cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned mcnt3 = 0;
  int unsigned mcnt1 = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    check(nm, 32'(act), 32'(exp));
  endtask

  function automatic rsp_t model_read(input logic [31:0] a);
    rsp_t        r;
    int unsigned w;
    w      = a >> 2;
    r.err  = (a[1:0] != 2'b00) || (a >= MEM_BYTES);
    r.data = '0;
    if (a < MEM_BYTES && mm.exists(w) != 0) r.data = mm[w];
    return r;
  endfunction

  // Model: log each sampled request, then apply the load (old word wins on a collision)
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rstn && rv) req_log[cyc] = model_read(ra);
    if (lv && la < MEM_BYTES) mm[la >> 2] = ld;
  end

  initial forever begin
    @(negedge rstn);
    req_log.delete();
    mcnt3 = 0;
    mcnt1 = 0;
  end

  task automatic cmp_dut(input string nm, input int lat, input logic v, input logic [31:0] d,
                         input logic e, input logic b, input logic [31:0] c,
                         inout int unsigned mc);
    int   t0;
    logic ev;
    logic eb;
    rsp_t r;
    t0 = cyc - lat + 1;
    ev = (req_log.exists(t0) != 0);
    eb = 1'b0;
    for (int k = t0; k <= cyc; k++) if (req_log.exists(k) != 0) eb = 1'b1;
    chk1({nm, "_valid"}, v, ev);
    chk1({nm, "_busy"}, b, eb);
    check({nm, "_count"}, c, mc);
    if (ev) begin
      r = req_log[t0];
      check({nm, "_data"}, d, r.data);
`ifdef IMEM_BUS_ERR_EN
      chk1({nm, "_err"}, e, r.err);
`endif
      mc++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp_dut("L3", 3, bus3.bus_rsp_valid, bus3.bus_rsp_data, err3, busy3, cnt3, mcnt3);
    cmp_dut("L1", 1, bus1.bus_rsp_valid, bus1.bus_rsp_data, err1, busy1, cnt1, mcnt1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic l,
                        input logic [31:0] lad, input logic [31:0] ldat);
    rv = v; ra = a; lv = l; la = lad; ld = ldat;
  endtask

  task automatic idle();
    set_in(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic req(input logic [31:0] a);
    set_in(1'b1, a, 1'b0, '0, '0);
  endtask

  initial begin
    idle();
    tick(); tick();
    rstn = 1'b1;

    for (int k = 0; k < 64; k++) begin
      set_in(1'b0, '0, 1'b1, 32'(k * 4), (k < 8) ? 32'(32'h100 + k) : 32'($urandom));
      tick();
    end
    idle();

    // back-to-back reads
    req(32'h0); tick(); req(32'h4); tick(); req(32'h8); tick();
    chk1("t1_v0", bus3.bus_rsp_valid, 1'b1); check("t1_d0", bus3.bus_rsp_data, 32'h100);
    idle(); tick();
    chk1("t1_v1", bus3.bus_rsp_valid, 1'b1); check("t1_d1", bus3.bus_rsp_data, 32'h101);
    tick();
    chk1("t1_v2", bus3.bus_rsp_valid, 1'b1); check("t1_d2", bus3.bus_rsp_data, 32'h102);
    tick();
    chk1("t1_vend", bus3.bus_rsp_valid, 1'b0); chk1("t1_busy", busy3, 1'b0);
    check("t1_count", cnt3, 32'd3);

    // gapped reads
    req(32'h10); tick(); idle(); tick(); req(32'h14); tick();
    chk1("t2_v0", bus3.bus_rsp_valid, 1'b1); check("t2_d0", bus3.bus_rsp_data, 32'h104);
    idle(); tick();
    chk1("t2_gap", bus3.bus_rsp_valid, 1'b0);
    tick();
    chk1("t2_v1", bus3.bus_rsp_valid, 1'b1); check("t2_d1", bus3.bus_rsp_data, 32'h105);
    tick(); tick();

    // read/load collision
    set_in(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEADBEEF); tick();
    req(32'h8); tick(); idle(); tick();
    check("t3_old", bus3.bus_rsp_data, 32'h102);
    tick();
    check("t3_new", bus3.bus_rsp_data, 32'hDEADBEEF);
    tick(); tick();

    // out-of-range and misaligned
    req(32'h0008_0000); tick(); req(32'h6); tick(); idle(); tick();
    chk1("t4_oor_v", bus3.bus_rsp_valid, 1'b1); check("t4_oor_d", bus3.bus_rsp_data, 32'h0);
`ifdef IMEM_BUS_ERR_EN
    chk1("t4_oor_err", err3, 1'b1);
`endif
    tick();
    check("t4_mis_d", bus3.bus_rsp_data, 32'h101);
`ifdef IMEM_BUS_ERR_EN
    chk1("t4_mis_err", err3, 1'b1);
`endif
    tick(); tick();

    // reset mid-flight
    req(32'h0); tick(); req(32'h4); tick(); req(32'h8);
    rstn = 1'b0;
    #1;
    chk1("t5_v3", bus3.bus_rsp_valid, 1'b0); check("t5_d3", bus3.bus_rsp_data, 32'h0);
    chk1("t5_b3", busy3, 1'b0); check("t5_c3", cnt3, 32'h0);
    chk1("t5_v1", bus1.bus_rsp_valid, 1'b0); check("t5_c1", cnt1, 32'h0);
    tick();
    rstn = 1'b1; idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("t5_quiet", bus3.bus_rsp_valid, 1'b0);
    end
    req(32'h4); tick(); idle(); tick(); tick();
    check("t5_mem", bus3.bus_rsp_data, 32'h101);
    tick(); tick();

    // continuous stream
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req(32'(k * 4)); tick();
      chk1("t6_v", bus1.bus_rsp_valid, 1'b1);
    end
    idle(); tick();
    chk1("t6_vend", bus1.bus_rsp_valid, 1'b0);
    tick(); tick();
    check("t6_c1", cnt1, 32'd16); check("t6_c3", cnt3, 32'd16);

    // randomized traffic with loads, out-of-range loads and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] a;
      logic        l;
      logic [31:0] lad;
      if ($urandom_range(399) == 0) begin
        idle(); rstn = 1'b0; tick(); rstn = 1'b1;
      end else begin
        r = $urandom_range(99);
        if (r < 70)      a = 32'($urandom_range(63)) << 2;
        else if (r < 85) a = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
        else             a = ($urandom & 32'hFFF8_0000) | MEM_BYTES | (32'($urandom_range(63)) << 2);
        l   = ($urandom_range(4) == 0);
        lad = 32'($urandom_range(63)) << 2;
        if ($urandom_range(3) == 0) lad = lad | MEM_BYTES;
        set_in($urandom_range(9) < 7, a, l, lad, $urandom);
        tick();
      end
    end
    idle();
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
